// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - display mode type and mode sequencing for led_pattern_ctrl
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_CHASE = 2'd2,
      MODE_PWM   = 2'd3
   } mode_t;

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_OFF:   return MODE_BLINK;
         MODE_BLINK: return MODE_CHASE;
         MODE_CHASE: return MODE_PWM;
         default:    return MODE_OFF;
      endcase
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - button synchroniser, debouncer and press-edge detect
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic db,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1;
   logic          s;
   logic          db_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         s     <= 1'b1;
         db    <= 1'b1;
         db_d  <= 1'b1;
         cnt   <= '0;
      end else begin
         sync1 <= button;
         s     <= sync1;
         db_d  <= db;
         // a level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles
         if (s == db) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db  <= s;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign press = ~db & db_d;

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - push-button stepped LED pattern controller (off, blink, chase, PWM ramp)
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int NUM_LEDS        = 3,
   parameter int CNT_WIDTH       = 27,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int PWM_WIDTH       = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                button,
   output logic [NUM_LEDS-1:0] leds,
   output logic [1:0]          mode
);

   localparam logic [NUM_LEDS-1:0] CHASE_INIT = NUM_LEDS'(1);

   logic                 db;
   logic                 press;
   logic                 adv;
   mode_t                mode_r;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 tick;
   logic                 blink;
   logic [NUM_LEDS-1:0]  chase;
   logic [PWM_WIDTH-1:0] duty;
   logic [PWM_WIDTH-1:0] phase;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk   (clk),
      .rst   (rst),
      .button(button),
      .db    (db),
      .press (press)
   );

   assign adv   = press & ~db;
   assign tick  = &cnt;
   assign phase = cnt[PWM_WIDTH-1:0];
   assign mode  = mode_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_r <= MODE_OFF;
         cnt    <= '0;
         blink  <= 1'b0;
         chase  <= CHASE_INIT;
         duty   <= '0;
         leds   <= '0;
      end else begin
         // a press reloads the pattern state and swallows any coincident tick
         if (adv) begin
            mode_r <= next_mode(mode_r);
            cnt    <= '0;
            blink  <= 1'b0;
            chase  <= CHASE_INIT;
            duty   <= '0;
         end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (tick) begin
               case (mode_r)
                  MODE_BLINK: blink <= ~blink;
                  MODE_CHASE: chase <= {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
                  MODE_PWM:   duty  <= duty + PWM_WIDTH'(1);
                  default:    ;
               endcase
            end
         end

         case (mode_r)
            MODE_BLINK: leds <= {NUM_LEDS{blink}};
            MODE_CHASE: leds <= chase;
            MODE_PWM:   leds <= {NUM_LEDS{phase < duty}};
            default:    leds <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - directed self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       button = 1'b1;
   logic [2:0] leds;
   logic [1:0] mode;

   int checks = 0;
   int failures = 0;
   int lit;
   int dark;

   led_pattern_ctrl #(
      .NUM_LEDS       (3),
      .CNT_WIDTH      (4),
      .DEBOUNCE_CYCLES(4),
      .PWM_WIDTH      (3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .button(button),
      .leds  (leds),
      .mode  (mode)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // button low from the next edge k; mode must change at edge k+6, then the button is released
   task automatic do_press(input logic [1:0] exp_mode);
      button = 1'b0;
      step(7);
      check_eq("mode_adv", {30'd0, mode}, {30'd0, exp_mode});
      button = 1'b1;
   endtask

   initial begin
      // reset
      step(3);
      check_eq("rst_leds", {29'd0, leds}, 32'd0);
      check_eq("rst_mode", {30'd0, mode}, 32'd0);
      rst = 1'b0;
      step(100);
      check_eq("idle_leds", {29'd0, leds}, 32'd0);
      check_eq("idle_mode", {30'd0, mode}, 32'd0);

      // bounce: 3 low, 1 high never satisfies the 4-cycle debounce
      repeat (6) begin
         button = 1'b0;
         step(3);
         button = 1'b1;
         step(1);
      end
      step(8);
      check_eq("bounce_mode", {30'd0, mode}, 32'd0);
      check_eq("bounce_leds", {29'd0, leds}, 32'd0);

      // held press into BLINK, exact latency
      button = 1'b0;
      step(6);
      check_eq("press_early", {30'd0, mode}, 32'd0);
      step(1);
      check_eq("press_k6", {30'd0, mode}, 32'd1);
      step(1);
      check_eq("blink_r1", {29'd0, leds}, 32'd0);
      step(15);
      check_eq("blink_r16", {29'd0, leds}, 32'd0);
      step(1);
      check_eq("blink_r17", {29'd0, leds}, 32'd7);
      step(15);
      check_eq("blink_r32", {29'd0, leds}, 32'd7);
      check_eq("blink_held_mode", {30'd0, mode}, 32'd1);
      step(1);
      check_eq("blink_r33", {29'd0, leds}, 32'd0);
      button = 1'b1;
      step(10);
      check_eq("release_mode", {30'd0, mode}, 32'd1);

      // CHASE
      do_press(2'd2);
      step(1);
      check_eq("chase_r1", {29'd0, leds}, 32'd1);
      step(15);
      check_eq("chase_r16", {29'd0, leds}, 32'd1);
      step(1);
      check_eq("chase_r17", {29'd0, leds}, 32'd2);
      step(16);
      check_eq("chase_r33", {29'd0, leds}, 32'd4);
      step(16);
      check_eq("chase_r49", {29'd0, leds}, 32'd1);
      step(6);

      // PWM: after 5 ticks duty=5, lit 5 of every 8 cycles
      do_press(2'd3);
      step(81);
      lit = 0;
      dark = 0;
      for (int i = 0; i < 8; i++) begin
         if (leds == 3'b111) lit++;
         if (leds == 3'b000) dark++;
         step(1);
      end
      check_eq("pwm_d5_lit", lit, 32'd5);
      check_eq("pwm_d5_dark", dark, 32'd3);
      step(40);
      lit = 0;
      for (int i = 0; i < 16; i++) begin
         if (leds != 3'b000) lit++;
         step(1);
      end
      check_eq("pwm_wrap_lit", lit, 32'd0);
      step(4);

      // back to OFF
      do_press(2'd0);
      step(1);
      check_eq("off_leds", {29'd0, leds}, 32'd0);
      step(6);

      // reset mid-CHASE with the button held
      do_press(2'd1);
      step(6);
      do_press(2'd2);
      button = 1'b0;
      step(5);
      check_eq("pre_rst_mode", {30'd0, mode}, 32'd2);
      rst = 1'b1;
      step(1);
      check_eq("mid_rst_mode", {30'd0, mode}, 32'd0);
      check_eq("mid_rst_leds", {29'd0, leds}, 32'd0);
      step(2);
      rst = 1'b0;
      button = 1'b1;
      step(20);
      check_eq("post_rst_mode", {30'd0, mode}, 32'd0);
      do_press(2'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
